// File: rtl/rcas_seq_addsub.sv
// Multi-cycle ripple-carry add/sub, SLICE bits per cycle LSB first; optional ovf via RCAS_OVF_EN.
// Latency: operands accepted at edge T, out_valid at edge T+N (N = WIDTH/SLICE).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module rcas_seq_addsub #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             c_out
`ifdef RCAS_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int SL = (SLICE < 1) ? 1 : SLICE;
    localparam int N  = WIDTH / SL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (SLICE < 1) begin : g_bad_slice
            $error("rcas_seq_addsub: SLICE must be >= 1");
        end else if (WIDTH % SL != 0) begin : g_bad_width
            $error("rcas_seq_addsub: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              c_out_q, c_out_d;
`ifdef RCAS_OVF_EN
    logic              ovf_q, ovf_d;
`endif

    logic [SL-1:0]     a_k;
    logic [SL-1:0]     b_k;
    logic [SL:0]       slice_sum;
    logic [WIDTH-1:0]  sum_next;
    int                base;

    // Slice datapath: one SL-bit adder indexed by the slice counter.
    always_comb begin
        base      = int'(cnt_q) * SL;
        a_k       = a_q[base +: SL];
        b_k       = b_q[base +: SL];
        slice_sum = {1'b0, a_k} + {1'b0, b_k} + {{SL{1'b0}}, carry_q};
        sum_next  = sum_q;
        sum_next[base +: SL] = slice_sum[SL-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        c_out_d  = c_out_q;
`ifdef RCAS_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction as a + ~b + 1: invert b here, inject the +1 as carry-in.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sel}};
                    carry_d = sel;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = slice_sum[SL];
                sum_d   = sum_next;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = sum_next;
                    c_out_d  = slice_sum[SL];
`ifdef RCAS_OVF_EN
                    ovf_d    = (a_k[SL-1] == b_k[SL-1]) && (slice_sum[SL-1] != a_k[SL-1]);
`endif
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
`ifdef RCAS_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
`ifdef RCAS_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign c_out     = c_out_q;
`ifdef RCAS_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_rcas_seq_addsub.sv
// Bench for rcas_seq_addsub: three configurations (8/4, 32/32, 32/1) checked against an arithmetic model.
module tb_rcas_seq_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  in_valid_v;
    logic [2:0]  out_ready_v;
    logic [2:0]  sel_v;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];

    logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, co0, co1, co2;
    logic [7:0]  res0;
    logic [31:0] res1, res2;
    logic [2:0]  in_ready_v, out_valid_v, c_out_v;
    logic [31:0] res_v [3];
`ifdef RCAS_OVF_EN
    logic        ov0, ov1, ov2;
    logic [2:0]  ovf_v;
    assign ovf_v = {ov2, ov1, ov0};
`endif

    assign in_ready_v  = {rdy2, rdy1, rdy0};
    assign out_valid_v = {vld2, vld1, vld0};
    assign c_out_v     = {co2, co1, co0};
    always_comb begin
        res_v[0] = {24'd0, res0};
        res_v[1] = res1;
        res_v[2] = res2;
    end

    int W  [3] = '{8, 32, 32};
    int NS [3] = '{2, 1, 32};
    int errors = 0;
    int checks = 0;

    rcas_seq_addsub #(.WIDTH(8), .SLICE(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(rdy0),
        .a(a_v[0][7:0]), .b(b_v[0][7:0]), .sel(sel_v[0]), .out_valid(vld0),
        .out_ready(out_ready_v[0]), .result(res0), .c_out(co0)
`ifdef RCAS_OVF_EN
        , .ovf(ov0)
`endif
    );

    rcas_seq_addsub #(.WIDTH(32), .SLICE(32)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(rdy1),
        .a(a_v[1]), .b(b_v[1]), .sel(sel_v[1]), .out_valid(vld1),
        .out_ready(out_ready_v[1]), .result(res1), .c_out(co1)
`ifdef RCAS_OVF_EN
        , .ovf(ov1)
`endif
    );

    rcas_seq_addsub #(.WIDTH(32), .SLICE(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(rdy2),
        .a(a_v[2]), .b(b_v[2]), .sel(sel_v[2]), .out_valid(vld2),
        .out_ready(out_ready_v[2]), .result(res2), .c_out(co2)
`ifdef RCAS_OVF_EN
        , .ovf(ov2)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from true signed range.
    function automatic void model(input int w, input logic [31:0] x, input logic [31:0] y,
                                  input bit s, output logic [31:0] r, output bit c, output bit v);
        longint unsigned mask, ux, uy, full;
        longint sx, sy, st, lim;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        ux   = longint'(x) & mask;
        uy   = longint'(y) & mask;
        sx   = (((ux >> (w - 1)) & 1) != 0) ? longint'(ux) - (lim << 1) : longint'(ux);
        sy   = (((uy >> (w - 1)) & 1) != 0) ? longint'(uy) - (lim << 1) : longint'(uy);
        if (s) begin
            r  = 32'((ux - uy) & mask);
            c  = (ux >= uy);
            st = sx - sy;
        end else begin
            full = ux + uy;
            r  = 32'(full & mask);
            c  = ((full >> w) != 0);
            st = sx + sy;
        end
        v = (st > lim - 1) || (st < -lim);
    endfunction

    task automatic do_op(input int d, input logic [31:0] x, input logic [31:0] y,
                         input bit s, input int hold);
        logic [31:0] er;
        bit          ec, ev;
        int          cyc;
        model(W[d], x, y, s, er, ec, ev);
        check_eq("in_ready_idle", 64'(in_ready_v[d]), 64'd1);
        a_v[d] = x; b_v[d] = y; sel_v[d] = s; in_valid_v[d] = 1'b1;
        @(posedge clk); #1;
        a_v[d] = $urandom; b_v[d] = $urandom; sel_v[d] = 1'($urandom);
        in_valid_v[d] = 1'b0;
        check_eq("in_ready_run", 64'(in_ready_v[d]), 64'd0);
        cyc = 0;
        while (!out_valid_v[d] && cyc < 64) begin
            in_valid_v[d] = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid_v[d] = 1'b0;
        check_eq("latency", 64'(cyc), 64'(NS[d]));
        check_eq("result", 64'(res_v[d]), 64'(er));
        check_eq("c_out", 64'(c_out_v[d]), 64'(ec));
`ifdef RCAS_OVF_EN
        check_eq("ovf", 64'(ovf_v[d]), 64'(ev));
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid_v[d] = 1'($urandom);
            a_v[d] = $urandom; b_v[d] = $urandom;
            @(posedge clk); #1;
            check_eq("hold_result", 64'(res_v[d]), 64'(er));
            check_eq("hold_out_valid", 64'(out_valid_v[d]), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready_v[d]), 64'd0);
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[d] = 1'b0;
        check_eq("handoff_out_valid", 64'(out_valid_v[d]), 64'd0);
        check_eq("handoff_in_ready", 64'(in_ready_v[d]), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid_v = '0; out_ready_v = '0; sel_v = '0;
        for (int i = 0; i < 3; i++) begin
            a_v[i] = '0; b_v[i] = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_in_ready", 64'(in_ready_v[i]), 64'd1);
            check_eq("rst_out_valid", 64'(out_valid_v[i]), 64'd0);
            check_eq("rst_result", 64'(res_v[i]), 64'd0);
            check_eq("rst_c_out", 64'(c_out_v[i]), 64'd0);
`ifdef RCAS_OVF_EN
            check_eq("rst_ovf", 64'(ovf_v[i]), 64'd0);
`endif
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(0, 32'h3C, 32'h15, 1'b0, 0);
        do_op(0, 32'h15, 32'h3C, 1'b1, 0);
        do_op(0, 32'h3C, 32'h15, 1'b1, 0);
        do_op(0, 32'hFF, 32'h01, 1'b0, 0);
        do_op(0, 32'h7F, 32'h01, 1'b0, 0);
        do_op(0, 32'h80, 32'h01, 1'b1, 5);

        // Reset in the middle of RUN (slice counter at 1).
        a_v[0] = 32'h3C; b_v[0] = 32'h15; sel_v[0] = 1'b0; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("midrun_rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check_eq("midrun_rst_in_ready", 64'(in_ready_v[0]), 64'd1);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(0, 32'hA7, 32'h6B, 1'b0, 0);

        do_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
        do_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
        do_op(1, 32'h8000_0000, 32'h1, 1'b1, 2);
        do_op(2, 32'h7FFF_FFFF, 32'h1, 1'b0, 2);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 20; n++) begin
                do_op(d, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
